// File: rtl/decoder_sched.sv
// Round-robin scheduler sharing one decoder datapath between NREQ requesters.
// Optional `DECODER_SCHED_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module decoder_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned CODE_W  = 7,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned DEC_LAT = 2
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic [NREQ-1:0]                   req_valid_i,
    input  logic [NREQ*CODE_W-1:0]            req_code_i,
    output logic [NREQ-1:0]                   req_ready_o,
    output logic [CODE_W-1:0]                 dec_in_o,
    input  logic [OUT_W-1:0]                  dec_out_i,
    output logic                              resp_valid_o,
    input  logic                              resp_ready_i,
    output logic [OUT_W-1:0]                  resp_data_o,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] resp_id_o,
    output logic                              busy_o
);

    localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {StIdle, StHold, StResp} state_e;

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   dec_in_q, dec_in_d;
    logic [OUT_W-1:0]    resp_data_q, resp_data_d;
    logic [IdW-1:0]      resp_id_q, resp_id_d;
    logic                resp_valid_q, resp_valid_d;
    logic [IdW-1:0]      last_q, last_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic                found;
    logic [IdW-1:0]      winner;
    logic [IdW-1:0]      cand;
    logic [CODE_W-1:0]   code_sel;
    logic                upd_last;

    // Search starts one past the previous winner and wraps modulo NREQ.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        upd_last = 1'b1;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IdW'((32'(last_q) + k) % NREQ);
            if (!found && req_valid_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`ifdef DECODER_SCHED_PRIO0_EN
        if (req_valid_i[0]) begin
            found    = 1'b1;
            winner   = '0;
            upd_last = 1'b0;
        end
`endif
    end

    always_comb begin
        code_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == IdW'(i)) begin
                code_sel = req_code_i[i*CODE_W +: CODE_W];
            end
        end
    end

    // Grant strobe is gated by reset so it reads zero while reset is held.
    always_comb begin
        req_ready_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready_o[i] = !reset_i && (state_q == StIdle) && found && (winner == IdW'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        dec_in_d     = dec_in_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = resp_valid_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    dec_in_d  = code_sel;
                    resp_id_d = winner;
                    if (upd_last) begin
                        last_d = winner;
                    end
                    cnt_d   = CntW'(DEC_LAT - 1);
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    resp_data_d  = dec_out_i;
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            dec_in_q     <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
            last_q       <= IdW'(NREQ - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            dec_in_q     <= dec_in_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
        end
    end

    assign dec_in_o     = dec_in_q;
    assign resp_data_o  = resp_data_q;
    assign resp_id_o    = resp_id_q;
    assign resp_valid_o = resp_valid_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_decoder_sched.sv
// Scoreboard bench for decoder_sched: stimulus pushes expected grants/responses,
// negedge monitors pop and compare. Decoder model returns code + 1.
module tb_decoder_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [27:0] req_code;
    logic [3:0]  req_ready;
    logic [6:0]  dec_in;
    logic [7:0]  dec_out;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [7:0]  resp_data;
    logic [1:0]  resp_id;
    logic        busy;
    logic [6:0]  codes [4];

    assign req_code = {codes[3], codes[2], codes[1], codes[0]};
    assign dec_out  = {1'b0, dec_in} + 8'd1;

    decoder_sched #(.NREQ(4), .CODE_W(7), .OUT_W(8), .DEC_LAT(2)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_code_i   (req_code),
        .req_ready_o  (req_ready),
        .dec_in_o     (dec_in),
        .dec_out_i    (dec_out),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_id_o    (resp_id),
        .busy_o       (busy)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int grants_seen = 0;
    int zero_grants = 0;
    int m_last = 3;
    logic [3:0] exp_grant_q [$];
    logic [9:0] exp_resp_q [$];
    int         gcyc_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Grant and response monitors.
    always @(negedge clock) begin
        if (!reset && req_ready != 4'b0000) begin
            grants_seen++;
            gcyc_q.push_back(cyc);
            if (req_ready == 4'b0001) zero_grants++;
            if (exp_grant_q.size() == 0) check("unexpected_grant", 32'(req_ready), 32'h0);
            else check("grant", 32'(req_ready), 32'(exp_grant_q.pop_front()));
        end
        if (!reset && resp_valid && resp_ready) begin
            if (exp_resp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got id=%0d data=0x%0h, expected none", resp_id,
                         resp_data);
            end else begin
                check("resp_id_data", 32'({resp_id, resp_data}), 32'(exp_resp_q.pop_front()));
            end
        end
    end

    // Reference arbitration: next valid requester after m_last, wrapping.
    function automatic logic [3:0] m_pick(input logic [3:0] v);
        int w = -1;
`ifdef DECODER_SCHED_PRIO0_EN
        if (v[0]) return 4'b0001;
`endif
        for (int k = 1; k <= 4; k++) begin
            if (w < 0 && v[(m_last + k) % 4]) w = (m_last + k) % 4;
        end
        m_last = w;
        return 4'b0001 << w;
    endfunction

    task automatic push_txn(input logic [3:0] v, input int n, input bit with_resp);
        logic [3:0] g;
        for (int i = 0; i < n; i++) begin
            g = m_pick(v);
            exp_grant_q.push_back(g);
            for (int j = 0; j < 4; j++) begin
                if (with_resp && g[j]) exp_resp_q.push_back({2'(j), {1'b0, codes[j]} + 8'd1});
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_grants(input int n);
        int k = 0;
        while (grants_seen < n && k < 200) begin
            step();
            k++;
        end
        check("grant_wait_timeout", 32'(grants_seen >= n), 32'h1);
    endtask

    task automatic wait_done();
        int k = 0;
        while ((exp_grant_q.size() != 0 || exp_resp_q.size() != 0 || busy) && k < 200) begin
            step();
            k++;
        end
        check("done_wait_timeout", 32'(k < 200), 32'h1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_dec_in"}, 32'(dec_in), 32'h0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        check({tag, "_resp_data"}, 32'(resp_data), 32'h0);
        check({tag, "_resp_id"}, 32'(resp_id), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100us");
        $fatal(1);
    end

    initial begin
        codes = '{7'h4C, 7'h11, 7'h22, 7'h33};
        req_valid = 4'b1111;
        step();
        step();
        check_zero("reset");

        // All requesters valid from reset release: grants 0,1,2,3,0, one every 4 cycles.
        push_txn(4'b1111, 5, 1'b1);
        grants_seen = 0;
        gcyc_q.delete();
        reset = 1'b0;
        wait_grants(5);
        req_valid = 4'b0000;
        wait_done();
        check("rr_grant_count", 32'(gcyc_q.size()), 32'd5);
        if (gcyc_q.size() >= 5) begin
            for (int i = 0; i < 4; i++) check("rr_interval", 32'(gcyc_q[i+1] - gcyc_q[i]), 32'd4);
        end

        // Single requester 2, code 4C: dec_in from cycle 1, response 4D at cycle 3.
        codes[2] = 7'h4C;
        push_txn(4'b0100, 1, 1'b1);
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        check("c1_dec_in", 32'(dec_in), 32'h4C);
        check("c1_busy", 32'(busy), 32'h1);
        check("c1_resp_valid", 32'(resp_valid), 32'h0);
        step();
        check("c2_resp_valid", 32'(resp_valid), 32'h0);
        step();
        check("c3_resp_valid", 32'(resp_valid), 32'h1);
        check("c3_resp_data", 32'(resp_data), 32'h4D);
        check("c3_resp_id", 32'(resp_id), 32'h2);
        wait_done();
        codes[2] = 7'h22;

        // Back-pressure: requester 3 wins, stalls 10 cycles in RESP.
        resp_ready = 1'b0;
        push_txn(4'b1111, 1, 1'b1);
        req_valid = 4'b1111;
        begin
            int k = 0;
            while (!resp_valid && k < 50) begin
                step();
                k++;
            end
            check("stall_resp_wait", 32'(resp_valid), 32'h1);
        end
        for (int i = 0; i < 10; i++) begin
            check("stall_resp_valid", 32'(resp_valid), 32'h1);
            check("stall_resp_data", 32'(resp_data), 32'h34);
            check("stall_dec_in", 32'(dec_in), 32'h33);
            check("stall_req_ready", 32'(req_ready), 32'h0);
            step();
        end
        push_txn(4'b1111, 1, 1'b1);
        resp_ready = 1'b1;
        step();
        check("post_hs_busy", 32'(busy), 32'h0);
        check("post_hs_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        wait_done();

        // Reset during HOLD aborts the transaction; requester 0 wins next.
        push_txn(4'b1000, 1, 1'b0);
        req_valid = 4'b1000;
        step();
        req_valid = 4'b0000;
        check("hold_busy", 32'(busy), 32'h1);
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        m_last = 3;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_resp_after_abort", 32'(resp_valid), 32'h0);
        end
        push_txn(4'b1111, 1, 1'b1);
        req_valid = 4'b1111;
        step();
        req_valid = 4'b0000;
        wait_done();

        // Set last=1 via requester 1, then 1 and 3 valid: grants 3 then 1.
        push_txn(4'b0010, 1, 1'b1);
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        wait_done();
        grants_seen = 0;
        push_txn(4'b1010, 2, 1'b1);
        req_valid = 4'b1010;
        wait_grants(2);
        req_valid = 4'b0000;
        wait_done();

        // Fairness over 8 transactions with all requesters valid.
        grants_seen = 0;
        zero_grants = 0;
        push_txn(4'b1111, 8, 1'b1);
        req_valid = 4'b1111;
        wait_grants(8);
        req_valid = 4'b0000;
        wait_done();
`ifdef DECODER_SCHED_PRIO0_EN
        check("req0_grant_count", 32'(zero_grants), 32'd8);
`else
        check("req0_grant_count", 32'(zero_grants), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
